// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] rs1_D;
  logic [REG_W-1:0] rs2_D;
  logic [REG_W-1:0] rd_E;
  logic             load_E;
  logic             pc_src_E;
  logic             md_start_E;
  logic             md_done;

  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             flush_D;
  logic             flush_E;
  logic             flush_M;
  logic             md_busy;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_D, rs2_D, rd_E, load_E, pc_src_E, md_start_E, md_done,
    input  stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
    input  md_busy, md_err, stall_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rd_E, load_E, pc_src_E, md_start_E, md_done,
    output stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
    output md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: mul/div wait with timeout, branch flush, load-use stall.
// Stall/flush controls are combinational so they act in the cycle the hazard is seen.
module hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              md_err_q, md_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;
  logic busy;
  logic load_use;

  assign load_use = hz.load_E && (hz.rd_E != 5'd0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));

  // Next state and controls; everything held low while reset is asserted.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    md_err_d = md_err_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    busy     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (hz.md_start_E) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            wait_d  = '0;
            state_d = MD_WAIT;
          end else if (hz.pc_src_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        MD_WAIT: begin
          if (hz.md_done) begin
            // Result arrives: release the pipeline in this same cycle.
            state_d = RUN;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            busy    = 1'b1;
            if (wait_q == WAIT_LAST) begin
              md_err_d = 1'b1;
              state_d  = RUN;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating count of fetch-stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_f && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wait_q   <= '0;
      md_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      md_err_q <= md_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hz.stall_F   = stall_f;
  assign hz.stall_D   = stall_d;
  assign hz.stall_E   = stall_e;
  assign hz.flush_D   = flush_d;
  assign hz.flush_E   = flush_e;
  assign hz.flush_M   = flush_m;
  assign hz.md_busy   = busy;
  assign hz.md_err    = md_err_q;
  assign hz.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
  localparam int unsigned TO      = 8;
  localparam int unsigned CW      = 6;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  int n_tests;
  int n_fail;
  int seen_sf;
  int seen_busy;

  // Model state: in a mul/div wait, cycles waited so far, sticky error, stall count.
  bit m_md;
  int m_waited;
  bit m_err;
  int m_cnt;

  logic [6:0] obs;
  assign obs = {bus.stall_F, bus.stall_D, bus.stall_E,
                bus.flush_D, bus.flush_E, bus.flush_M, bus.md_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rs1_D      = 5'd0;
    bus.rs2_D      = 5'd0;
    bus.rd_E       = 5'd0;
    bus.load_E     = 1'b0;
    bus.pc_src_E   = 1'b0;
    bus.md_start_E = 1'b0;
    bus.md_done    = 1'b0;
  endtask

  task automatic model_reset();
    m_md     = 1'b0;
    m_waited = 0;
    m_err    = 1'b0;
    m_cnt    = 0;
  endtask

  // Expected {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, md_busy}.
  function automatic logic [6:0] model_outs();
    bit lu;
    lu = bus.load_E && (bus.rd_E != 0) &&
         ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));
    if (m_md) begin
      if (bus.md_done) return 7'b000_0000;
      return 7'b111_0011;
    end
    if (bus.md_start_E) return 7'b111_0010;
    if (bus.pc_src_E)   return 7'b000_1100;
    if (lu)             return 7'b110_0100;
    return 7'b000_0000;
  endfunction

  task automatic model_step(input logic [6:0] e);
    if (e[6] && m_cnt < CNT_MAX) m_cnt++;
    if (!m_md) begin
      if (bus.md_start_E) begin
        m_md     = 1'b1;
        m_waited = 0;
      end
    end else if (bus.md_done) begin
      m_md = 1'b0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        m_md  = 1'b0;
        m_err = 1'b1;
      end
    end
  endtask

  // Starts at a falling edge with inputs driven; ends at the next falling edge.
  task automatic run_cycle(input string tag);
    logic [6:0] e;
    #1;
    e = model_outs();
    check({tag, "_outs"}, 32'(obs), 32'(e));
    seen_sf   += int'(bus.stall_F);
    seen_busy += int'(bus.md_busy);
    @(posedge clk);
    model_step(e);
    #1;
    check({tag, "_err"}, 32'(bus.md_err), 32'(m_err));
    check({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    seen_sf   = 0;
    seen_busy = 0;
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("rst_outs", 32'(obs), 32'd0);
    check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_err", 32'(bus.md_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs2 for one cycle.
    bus.load_E = 1'b1; bus.rd_E = 5'd5; bus.rs2_D = 5'd5;
    run_cycle("lu_rs2");
    check("lu_rs2_cnt_abs", 32'(bus.stall_cnt), 32'd1);
    clear_inputs();
    run_cycle("lu_after");

    // Load to x0 never stalls.
    bus.load_E = 1'b1;
    run_cycle("lu_x0");
    check("lu_x0_cnt_abs", 32'(bus.stall_cnt), 32'd1);
    clear_inputs();

    // Mul/div released by md_done on the 4th wait cycle.
    seen_sf = 0; seen_busy = 0;
    bus.md_start_E = 1'b1;
    run_cycle("md_start");
    bus.md_start_E = 1'b0;
    repeat (3) run_cycle("md_wait");
    bus.md_done = 1'b1;
    run_cycle("md_done");
    bus.md_done = 1'b0;
    check("md_stall_cycles", 32'(seen_sf), 32'd4);
    check("md_busy_cycles", 32'(seen_busy), 32'd3);
    check("md_cnt_abs", 32'(bus.stall_cnt), 32'd5);
    run_cycle("md_run");

    // Mul/div timeout.
    seen_sf = 0; seen_busy = 0;
    bus.md_start_E = 1'b1;
    run_cycle("to_start");
    bus.md_start_E = 1'b0;
    repeat (TO + 1) run_cycle("to_wait");
    check("to_busy_cycles", 32'(seen_busy), 32'd8);
    check("to_err_abs", 32'(bus.md_err), 32'd1);
    check("to_cnt_abs", 32'(bus.stall_cnt), 32'd14);

    // Branch beats load-use.
    bus.pc_src_E = 1'b1; bus.load_E = 1'b1; bus.rd_E = 5'd3; bus.rs1_D = 5'd3;
    #1;
    check("br_lu_stall_F", 32'(bus.stall_F), 32'd0);
    check("br_lu_flush_DE", 32'({bus.flush_D, bus.flush_E}), 32'd3);
    run_cycle("br_lu");
    clear_inputs();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.rs1_D      = 5'($urandom_range(0, 3));
      bus.rs2_D      = 5'($urandom_range(0, 3));
      bus.rd_E       = 5'($urandom_range(0, 3));
      bus.load_E     = 1'($urandom_range(0, 1));
      bus.pc_src_E   = ($urandom_range(0, 4) == 0);
      bus.md_start_E = ($urandom_range(0, 7) == 0);
      bus.md_done    = ($urandom_range(0, 5) == 0);
      run_cycle("rand");
    end
    clear_inputs();

    // Reset in the middle of a mul/div wait.
    bus.md_done = 1'b1;
    run_cycle("pre_rst_flush");
    bus.md_done    = 1'b0;
    bus.md_start_E = 1'b1;
    run_cycle("rst_md_start");
    bus.md_start_E = 1'b0;
    #1;
    check("rst_md_busy_pre", 32'(bus.md_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    bus.md_start_E = 1'b1; bus.load_E = 1'b1; bus.rd_E = 5'd7; bus.rs1_D = 5'd7;
    #1;
    check("rst_mid_outs", 32'(obs), 32'd0);
    check("rst_mid_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_mid_err", 32'(bus.md_err), 32'd0);
    @(negedge clk);
    check("rst_hold_outs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    run_cycle("rst_release");
    check("rst_release_cnt_abs", 32'(bus.stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, max cycles waited in MD_WAIT for md_done.
REQ-002 SHALL have parameter CNT_W, default 32, width of stall_cnt.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rs1_D, rs2_D  in  5 each  source registers of instruction in Decode.
REQ-006 SHALL have port rd_E  in  5  destination register of instruction in Execute.
REQ-007 SHALL have port load_E  in  1  instruction in Execute is a load.
REQ-008 SHALL have port pc_src_E  in  1  taken branch/jump resolved in Execute.
REQ-009 SHALL have port md_start_E  in  1  multi-cycle mul/div op in Execute requests the unit.
REQ-010 SHALL have port md_done  in  1  mul/div unit result valid, one-cycle pulse.
REQ-011 SHALL have ports stall_F, stall_D, stall_E  out  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-012 SHALL have ports flush_D, flush_E, flush_M  out  1 each  clear IF/ID, ID/EX and EX/MEM registers to a bubble.
REQ-013 SHALL have port md_busy  out  1  FSM is in MD_WAIT.
REQ-014 SHALL have port md_err  out  1  sticky timeout flag.
REQ-015 SHALL have port stall_cnt  out  CNT_W  count of cycles with stall_F=1.

Function
REQ-016 SHALL implement FSM with states RUN and MD_WAIT, plus a wait counter of width clog2(MD_TIMEOUT)+1.
REQ-017 RUN with md_start_E=1 SHALL assert stall_F, stall_D, stall_E and flush_M combinationally that cycle, clear the wait counter, and go to MD_WAIT next edge.
REQ-018 MD_WAIT SHALL assert stall_F, stall_D, stall_E, flush_M and md_busy every cycle and increment the wait counter.
REQ-019 MD_WAIT with md_done=1 SHALL deassert all stalls and flush_M in that same cycle and go to RUN next edge (zero-cycle release).
REQ-020 MD_WAIT with wait counter = MD_TIMEOUT-1 and md_done=0 SHALL set md_err next edge and go to RUN; stalls still assert in that cycle.
REQ-021 md_done while in RUN SHALL be ignored.
REQ-022 Load-use hazard SHALL be load_E=1 & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D); in RUN it SHALL assert stall_F, stall_D and flush_E for exactly that cycle.
REQ-023 rd_E=0 SHALL never raise a load-use stall.
REQ-024 pc_src_E=1 in RUN SHALL assert flush_D and flush_E in that cycle; stall_F/stall_D SHALL NOT assert from the branch.
REQ-025 Priority SHALL be MD (REQ-017..020) > branch (REQ-024) > load-use (REQ-022); pc_src_E and load-use are ignored while stall_E=1.
REQ-026 With no hazard, all stall/flush outputs SHALL be 0.
REQ-027 stall_cnt SHALL increment by 1 on each edge where stall_F=1 and saturate at all-ones.
REQ-028 md_err SHALL stay 1 until reset; it does not block further operation.

Reset
REQ-029 rst_n=0 SHALL force state RUN, wait counter 0, md_err 0 and stall_cnt 0 immediately, without waiting for clk.
REQ-030 During reset, all stall/flush outputs and md_busy SHALL be 0; an MD_WAIT interrupted by reset SHALL NOT resume.

Verification
REQ-031 load_E=1, rd_E=5, rs2_D=5 for 1 cycle -> stall_F=stall_D=flush_E=1 that cycle only; stall_cnt=1.
REQ-032 load_E=1, rd_E=0, rs1_D=0 -> all outputs 0.
REQ-033 md_start_E=1, then md_done on 4th cycle of MD_WAIT -> stall_F=1 for 4 cycles (md_busy=1 for 3), 0 in the md_done cycle; state RUN after; stall_cnt=4.
REQ-034 md_start_E=1, md_done never, MD_TIMEOUT=8 -> md_busy=1 for 8 cycles, md_err=1 after, then RUN.
REQ-035 pc_src_E=1 and load-use hazard in the same cycle -> flush_D=flush_E=1, stall_F=0.
REQ-036 rst_n low mid MD_WAIT -> md_busy and stalls 0 asynchronously; after release, RUN with stall_cnt=0.
